// File: rtl/nand_resp_checker.sv
// Response checker for the WIDTH-bit NAND block: compares each (A, B, Y) vector against ~(A & B),
// counts passes/fails and captures the first failing vector; results land one edge after capture.
module nand_resp_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_valid,
   input  logic [WIDTH-1:0] vec_a,
   input  logic [WIDTH-1:0] vec_b,
   input  logic [WIDTH-1:0] vec_y,
   input  logic             vec_last,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] ff_idx,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic [WIDTH-1:0] ff_y
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state;
   logic [CNT_W-1:0] idx;
   logic             s1_vld;
   logic [CNT_W-1:0] s1_idx;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_y;

   logic accept;
   logic clear;
   logic s1_bad;

   assign accept = (state == S_RUN) && vec_valid;
   assign clear  = start && ((state == S_IDLE) || (state == S_DONE));
   assign s1_bad = (s1_y != ~(s1_a & s1_b));

   // busy/done decode straight from the state register, so no input reaches them combinationally
   assign busy = (state == S_RUN) || (state == S_CHECK);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         s1_vld   <= 1'b0;
         s1_idx   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_y     <= '0;
         err      <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         ff_idx   <= '0;
         ff_a     <= '0;
         ff_b     <= '0;
         ff_y     <= '0;
      end else begin
         case (state)
            S_IDLE:  if (start) state <= S_RUN;
            S_RUN:   if (accept && vec_last) state <= S_CHECK;
            S_CHECK: state <= S_DONE;
            default: if (start) state <= S_RUN;
         endcase

         if (clear) begin
            idx      <= '0;
            s1_vld   <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            ff_idx   <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_y     <= '0;
         end else begin
            s1_vld <= accept;
            if (accept) begin
               s1_idx <= idx;
               s1_a   <= vec_a;
               s1_b   <= vec_b;
               s1_y   <= vec_y;
               if (idx != CNT_MAX) idx <= idx + 1'b1;
            end

            // Stage 2: compare the vector captured on the previous edge
            if (s1_vld) begin
               if (s1_bad) begin
                  if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                  err <= 1'b1;
                  if (!err) begin
                     ff_idx <= s1_idx;
                     ff_a   <= s1_a;
                     ff_b   <= s1_b;
                     ff_y   <= s1_y;
                  end
               end else if (pass_cnt != CNT_MAX) begin
                  pass_cnt <= pass_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nand_resp_checker.sv
// Bench for nand_resp_checker: table-driven runs plus hand sequences, checked by a cycle model and scoreboard.
module tb_nand_resp_checker;
   localparam int W  = 4;
   localparam int CW = 4;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          vec_valid = 1'b0;
   logic          vec_last = 1'b0;
   logic [W-1:0]  vec_a = '0;
   logic [W-1:0]  vec_b = '0;
   logic [W-1:0]  vec_y = '0;
   logic          busy, done, err;
   logic [CW-1:0] pass_cnt, fail_cnt, ff_idx;
   logic [W-1:0]  ff_a, ff_b, ff_y;

   always #5 clk = ~clk;

   nand_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
      .vec_a(vec_a), .vec_b(vec_b), .vec_y(vec_y), .vec_last(vec_last),
      .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .ff_idx(ff_idx), .ff_a(ff_a), .ff_b(ff_b), .ff_y(ff_y)
   );

   typedef struct packed {
      logic [CW-1:0] pass;
      logic [CW-1:0] fail;
      logic [CW-1:0] idx;
      logic          err;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  y;
   } exp_t;

   typedef struct packed {
      logic         st;
      logic         v;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
      logic         l;
      logic         ok;
   } tv_t;

   int            n_tests = 0;
   int            n_fail = 0;
   exp_t          sb[$];
   exp_t          m;
   logic [CW-1:0] m_idx;
   int            m_state;
   logic          due;
   tv_t           tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
      return (x == CMAX) ? x : x + 1'b1;
   endfunction

   task automatic chk_res(input string tag, input exp_t e);
      chk({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(e.pass));
      chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(e.fail));
      chk({tag, ".err"},      32'(err),      32'(e.err));
      chk({tag, ".ff_idx"},   32'(ff_idx),   32'(e.idx));
      chk({tag, ".ff_a"},     32'(ff_a),     32'(e.a));
      chk({tag, ".ff_b"},     32'(ff_b),     32'(e.b));
      chk({tag, ".ff_y"},     32'(ff_y),     32'(e.y));
   endtask

   task automatic tick(input logic st, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] y, input logic l, input logic ok);
      exp_t e;
      start = st; vec_valid = v; vec_a = a; vec_b = b; vec_y = y; vec_last = l;
      @(posedge clk); #1;
      start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
      if (!rst_n) begin
         m = '0; m_idx = '0; m_state = 0; sb.delete(); due = 1'b0;
         chk("rst.busy", 32'(busy), 32'd0);
         chk("rst.done", 32'(done), 32'd0);
         chk_res("rst", m);
         return;
      end
      if (due) begin
         e = sb.pop_front();
         due = 1'b0;
         chk_res("sb", e);
      end
      case (m_state)
         0, 3: if (st) begin
            m = '0; m_idx = '0; m_state = 1;
         end
         1: if (v) begin
            if (ok) m.pass = sat(m.pass);
            else begin
               m.fail = sat(m.fail);
               if (!m.err) begin
                  m.idx = m_idx; m.a = a; m.b = b; m.y = y;
               end
               m.err = 1'b1;
            end
            m_idx = sat(m_idx);
            sb.push_back(m);
            due = 1'b1;
            if (l) m_state = 2;
         end
         default: m_state = 3;
      endcase
      chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
      chk("done", 32'(done), 32'(m_state == 3));
      if (!due) chk_res("hold", m);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic add(input logic st, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] y, input logic l, input logic ok);
      tv_t t;
      t.st = st; t.v = v; t.a = a; t.b = b; t.y = y; t.l = l; t.ok = ok;
      tbl.push_back(t);
   endtask

   initial begin
      logic [W-1:0] ra, rb, ry;
      m = '0; m_idx = '0; m_state = 0; due = 1'b0;

      // all-pass run, then a vector in DONE that must be ignored
      add(1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 1, 4'b0010, 4'b0010, 4'b1101, 0, 1);
      add(0, 1, 4'b0100, 4'b1000, 4'b1111, 0, 1);
      add(0, 1, 4'b1100, 4'b1111, 4'b0011, 1, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      // one failure at index 1, with a start pulse mid-run that must not restart
      add(1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 1, 4'b0010, 4'b0010, 4'b1101, 0, 1);
      add(1, 1, 4'b0100, 4'b1000, 4'b1110, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 1, 4'b1100, 4'b1111, 4'b0011, 1, 1);
      add(1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      // start+valid in DONE clears only; then failures at index 0 and 2
      add(1, 1, 4'b0100, 4'b1000, 4'b1111, 0, 1);
      add(0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0);
      add(0, 1, 4'b0100, 4'b1000, 4'b1111, 0, 1);
      add(0, 1, 4'b1100, 4'b1111, 4'b0000, 1, 0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      // restart after a failing run with a single matching last vector
      add(1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 1, 4'b1100, 4'b1111, 4'b0011, 1, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);

      // reset state, then vectors in IDLE are ignored
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      idle();
      tick(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b1110, 1'b1, 1'b1);
      idle();

      foreach (tbl[i]) tick(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].l, tbl[i].ok);

      // reset one cycle after a failing vector discards it
      tick(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      idle();

      // counter saturation: 20 passing vectors
      tick(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++)
         tick(1'b0, 1'b1, 4'(i), 4'b1010, ~(4'(i) & 4'b1010), i == 19, 1'b1);
      idle();
      // index saturation: first failure at index 18 reports the max index
      tick(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++)
         tick(1'b0, 1'b1, 4'(i), 4'b0110, (i == 18) ? 4'b0000 : ~(4'(i) & 4'b0110), i == 19, i != 18);
      idle();

      // random back-to-back run
      tick(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         ry = ~(ra & rb);
         if ($urandom_range(0, 2) == 0) ry = ry ^ 4'($urandom_range(1, 15));
         tick(1'b0, 1'b1, ra, rb, ry, i == 11, ry == ~(ra & rb));
      end
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
